// File: rtl/spi_frame_pkg.sv
// Shared widths, field positions and types for the SPI frame receiver.
package spi_frame_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FRAME_W    = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned GCNT_W     = 8;

  localparam int unsigned RW_BIT   = 15;
  localparam int unsigned ADDR_MSB = 14;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned DATA_MSB = 7;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

endpackage

// File: rtl/sync_edge.sv
// Pad synchroniser with history flop; emits aligned level, rise and fall.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;
  logic [STAGES:0]   prime_q, prime_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  // Edges are suppressed until the chain holds only post-reset samples, so a
  // pad already away from its idle level at reset release is not an edge.
  always_comb begin
    sync_d  = {sync_q[STAGES-2:0], pad};
    hist_d  = sync_q[STAGES-1];
    prime_d = {prime_q[STAGES-1:0], 1'b1};
    rise_d  = prime_q[STAGES] &  sync_q[STAGES-1] & ~hist_q;
    fall_d  = prime_q[STAGES] & ~sync_q[STAGES-1] &  hist_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {STAGES{RST_VAL}};
      hist_q  <= RST_VAL;
      prime_q <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      prime_q <= prime_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = hist_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: synchronises pads, assembles frames, strobes
// good frames with decoded fields and flags mis-sized ones.
module spi_frame_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = spi_frame_pkg::FRAME_BITS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              sclk,
  input  logic                              copi,
  input  logic                              ncs,
  output logic                              frame_valid,
  output logic                              frame_rw,
  output logic [spi_frame_pkg::ADDR_W-1:0]  frame_addr,
  output logic [spi_frame_pkg::DATA_W-1:0]  frame_data,
  output logic                              frame_err,
  output logic [spi_frame_pkg::GCNT_W-1:0]  good_count
);

  import spi_frame_pkg::*;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic unused_sync;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .pad   (sclk),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk   (clk),
    .rst_n (rst_n),
    .pad   (copi),
    .level (copi_lvl),
    .rise  (copi_rise),
    .fall  (copi_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk   (clk),
    .rst_n (rst_n),
    .pad   (ncs),
    .level (ncs_lvl),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  assign unused_sync = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall, ncs_lvl};

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  frame_t              frame_q, frame_d;
  logic [GCNT_W-1:0]   good_q, good_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  // Frame close takes priority over a coincident SCLK rise, which is dropped.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    good_d  = good_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          state_d = ACTIVE;
          shreg_d = '0;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        if (ncs_rise) begin
          state_d = IDLE;
          if (cnt_q == CNT_W'(FRAME_BITS)) begin
            valid_d      = 1'b1;
            frame_d.rw   = shreg_q[RW_BIT];
            frame_d.addr = shreg_q[ADDR_MSB:ADDR_LSB];
            frame_d.data = shreg_q[DATA_MSB:0];
            good_d       = good_q + GCNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[FRAME_W-2:0], copi_lvl};
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      frame_q <= '0;
      good_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      good_q  <= good_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign frame_rw    = frame_q.rw;
  assign frame_addr  = frame_q.addr;
  assign frame_data  = frame_q.data;
  assign good_count  = good_q;

endmodule
